// File: rtl/mips_memory.sv
// mips_memory: unified big-endian byte memory with single-word and fixed-length burst access.
// Define MEM_ADDR_ERR_EN to add the registered addr_err output flagging out-of-range beats.
module mips_memory #(
    parameter int data_width = 32,
    parameter int address_width = 32,
    parameter int depth = 1048576,
    parameter logic [address_width-1:0] start_addr = 32'h80020000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out
`ifdef MEM_ADDR_ERR_EN
    ,
    output logic                     addr_err
`endif
);
    localparam int aw = $clog2(depth);
    localparam logic [address_width-1:0] last_off = address_width'(depth - 4);
    logic [7:0] mem [depth];
    logic [address_width-1:0] base, off;
    logic [3:0] count, last, n_last;
    logic [aw-3:0] wi;
    logic rw_l, active, cur_rw, in_range;
    logic [31:0] word;
    always_comb begin
        n_last = access_size == 2'b00 ? 4'd0 :
                 access_size == 2'b01 ? 4'd3 :
                 access_size == 2'b10 ? 4'd7 : 4'd15;
        active = busy | enable;
        cur_rw = busy ? rw_l : rw;
        // during a burst the beat address comes from the latched base, not the bus
        off = busy ? base + address_width'({count, 2'b00})
                   : (address - start_addr) & ~address_width'(3);
        in_range = off <= last_off;
        wi = off[aw-1:2];
        word = {mem[{wi, 2'd0}], mem[{wi, 2'd1}], mem[{wi, 2'd2}], mem[{wi, 2'd3}]};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            count <= 4'd0;
            last <= 4'd0;
            base <= '0;
            rw_l <= 1'b0;
            data_out <= '0;
`ifdef MEM_ADDR_ERR_EN
            addr_err <= 1'b0;
`endif
        end else begin
            if (!busy && enable) begin
                base <= off;
                rw_l <= rw;
                last <= n_last;
                count <= 4'd1;
                busy <= n_last != 4'd0;
            end else if (busy) begin
                count <= count + 4'd1;
                if (count == last) busy <= 1'b0;
            end
            if (active && cur_rw) data_out <= in_range ? word : '0;
`ifdef MEM_ADDR_ERR_EN
            addr_err <= active && !in_range;
`endif
        end
    end
    // storage is deliberately left out of reset
    always_ff @(posedge clock) begin
        if (!reset && active && !cur_rw && in_range) begin
            mem[{wi, 2'd0}] <= data_in[31:24];
            mem[{wi, 2'd1}] <= data_in[23:16];
            mem[{wi, 2'd2}] <= data_in[15:8];
            mem[{wi, 2'd3}] <= data_in[7:0];
        end
    end
endmodule

// File: tb/tb_mips_memory.sv
// tb_mips_memory: directed vectors for mips_memory (single, burst, range, reset).
module tb_mips_memory;
    logic clock = 1'b0;
    logic reset, rw, enable, busy;
    logic [31:0] address, data_in, data_out;
    logic [1:0] access_size;
`ifdef MEM_ADDR_ERR_EN
    logic addr_err;
`endif
    int checks = 0;
    int failures = 0;
    logic [31:0] wd [16];
    logic [31:0] ew [16];

    always #5 clock = ~clock;

    mips_memory dut (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
        .data_out(data_out)
`ifdef MEM_ADDR_ERR_EN
        , .addr_err(addr_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [1:0] sz, input logic r, input logic [31:0] d);
        address = a;
        access_size = sz;
        rw = r;
        data_in = d;
        enable = 1'b1;
    endtask

    // for reads, d is the expected word
    task automatic single(input logic [31:0] a, input logic r, input logic [31:0] d, input string tag);
        start(a, 2'b00, r, d);
        step();
        enable = 1'b0;
        check({tag, " busy"}, {31'b0, busy}, 32'd0);
        if (r) check(tag, data_out, d);
    endtask

    // bus fields are scrambled after beat 0 to show they are ignored while busy
    task automatic burst(input logic [31:0] a, input logic [1:0] sz, input logic r, input int n, input string tag);
        start(a, sz, r, wd[0]);
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 0) begin
                address = 32'h0;
                access_size = 2'b11;
                rw = ~r;
            end
            if (k + 1 < n) data_in = wd[k + 1];
            if (k == n - 1) enable = 1'b0;
            check($sformatf("%s busy%0d", tag, k), {31'b0, busy}, {31'b0, k < n - 1});
            if (r) check($sformatf("%s data%0d", tag, k), data_out, ew[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        rw = 1'b1;
        address = '0;
        data_in = '0;
        access_size = 2'b00;
        step();
        step();
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst data_out", data_out, 32'd0);
        reset = 1'b0;
        single(32'h80020000, 1'b0, 32'h27BDFFF8, "wr0");
        single(32'h80020000, 1'b1, 32'h27BDFFF8, "rd0");
        single(32'h80020004, 1'b0, 32'h11223344, "wr4");
        single(32'h80020006, 1'b1, 32'h11223344, "rd_unaligned");
        single(32'h80020000, 1'b0, 32'hAABBCCDD, "wr_endian");
        single(32'h80020000, 1'b1, 32'hAABBCCDD, "rd_endian");
        step();
        check("idle hold", data_out, 32'hAABBCCDD);
        for (int k = 0; k < 4; k++) begin
            wd[k] = 32'(k + 1);
            ew[k] = 32'(k + 1);
        end
        burst(32'h80020010, 2'b01, 1'b0, 4, "bw4");
        burst(32'h80020010, 2'b01, 1'b1, 4, "br4");
        single(32'h00000000, 1'b0, 32'hDEADBEEF, "wr_oor_low");
        single(32'h00000000, 1'b1, 32'h0, "rd_oor_low");
        single(32'h8011FFFC, 1'b0, 32'h55AA55AA, "wr_last");
        single(32'h8011FFFC, 1'b1, 32'h55AA55AA, "rd_last");
`ifdef MEM_ADDR_ERR_EN
        check("addr_err in range", {31'b0, addr_err}, 32'd0);
`endif
        single(32'h80120000, 1'b1, 32'h0, "rd_end");
`ifdef MEM_ADDR_ERR_EN
        check("addr_err set", {31'b0, addr_err}, 32'd1);
        step();
        check("addr_err clear", {31'b0, addr_err}, 32'd0);
`endif
        for (int k = 0; k < 4; k++) wd[k] = 32'(16 + k);
        ew[0] = 32'd16;
        ew[1] = 32'd17;
        ew[2] = 32'd0;
        ew[3] = 32'd0;
        burst(32'h8011FFF8, 2'b01, 1'b0, 4, "bw_cross");
        burst(32'h8011FFF8, 2'b01, 1'b1, 4, "br_cross");
        single(32'h80020000, 1'b1, 32'hAABBCCDD, "no_wrap");
        for (int k = 0; k < 8; k++) wd[k] = 32'hA0 + 32'(k);
        burst(32'h80020100, 2'b10, 1'b0, 8, "prefill");
        single(32'h80020000, 1'b1, 32'hAABBCCDD, "pre_rst");
        start(32'h80020100, 2'b10, 1'b0, 32'hB0);
        step();
        data_in = 32'hB1;
        step();
        data_in = 32'hB2;
        step();
        data_in = 32'hB3;
        reset = 1'b1;
        step();
        reset = 1'b0;
        enable = 1'b0;
        check("mid rst busy", {31'b0, busy}, 32'd0);
        check("mid rst data_out", data_out, 32'd0);
        for (int k = 0; k < 8; k++) ew[k] = k < 3 ? 32'hB0 + 32'(k) : 32'hA0 + 32'(k);
        burst(32'h80020100, 2'b10, 1'b1, 8, "rst_rb");
        single(32'h80020000, 1'b1, 32'hAABBCCDD, "post_rst");
        for (int k = 0; k < 16; k++) begin
            wd[k] = 32'hC0000000 + 32'(k);
            ew[k] = 32'hC0000000 + 32'(k);
        end
        burst(32'h80020200, 2'b11, 1'b0, 16, "bw16");
        burst(32'h80020200, 2'b11, 1'b1, 16, "br16");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
